// File: rtl/multi_channel_pulse_gen.sv
// multi_channel_pulse_gen: N-channel monostable with shared pulse length and optional retrigger.
// Define MULTI_PULSE_HOLDOFF_EN to add the holdoff_len port and a post-pulse HOLDOFF dead time.
module multi_channel_pulse_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CNT_W-1:0]    pulse_len,
  input  logic                retrig_en,
`ifdef MULTI_PULSE_HOLDOFF_EN
  input  logic [CNT_W-1:0]    holdoff_len,
`endif
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy
);
  typedef enum logic [1:0] {IDLE, PULSE, WAIT, HOLDOFF} state_t;
  logic [CNT_W-1:0] len_m1;
  logic [CNT_W-1:0] exp_cnt;
  state_t           exp_st;
  assign len_m1 = (pulse_len != '0) ? pulse_len - CNT_W'(1) : '0;
`ifdef MULTI_PULSE_HOLDOFF_EN
  assign exp_st  = (holdoff_len != '0) ? HOLDOFF : WAIT;
  assign exp_cnt = (holdoff_len != '0) ? holdoff_len - CNT_W'(1) : '0;
`else
  assign exp_st  = WAIT;
  assign exp_cnt = '0;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : ch
    state_t           st, nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tq, rise, p, b;
    assign rise     = trigger[c] & ~tq;
    assign pulse[c] = p;
    assign busy[c]  = b;
    always_comb begin
      nxt   = st;
      cnt_d = cnt;
      case (st)
        IDLE: if (trigger[c]) begin
          nxt   = (pulse_len != '0) ? PULSE : WAIT;
          cnt_d = len_m1;
        end
        // a zero length cannot be reloaded, so such a retrigger falls through to expiry
        PULSE: if (retrig_en && rise && pulse_len != '0)
          cnt_d = len_m1;
        else if (cnt == '0) begin
          nxt   = exp_st;
          cnt_d = exp_cnt;
        end else
          cnt_d = cnt - CNT_W'(1);
        WAIT: if (!trigger[c]) nxt = IDLE;
`ifdef MULTI_PULSE_HOLDOFF_EN
        HOLDOFF: if (cnt == '0) nxt = WAIT;
        else cnt_d = cnt - CNT_W'(1);
`endif
        default: nxt = IDLE;
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st  <= IDLE;
        cnt <= '0;
        tq  <= 1'b0;
        p   <= 1'b0;
        b   <= 1'b0;
      end else begin
        st  <= nxt;
        cnt <= cnt_d;
        tq  <= trigger[c];
        p   <= nxt == PULSE;
        b   <= nxt != IDLE;
      end
    end
  end
endmodule
